// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed segment display driver.
// Holds the default geometry and a hex-to-7-segment encoder (gfedcba order).
package seg_pkg;

  localparam int DEF_NUM_DIGITS     = 4;
  localparam int DEF_SEG_W          = 7;
  localparam int DEF_DIV_BITS       = 18;
  localparam int DEF_BLANK_CYCLES   = 256;
  localparam int DEF_AN_ACTIVE_LOW  = 1;
  localparam int DEF_SEG_ACTIVE_LOW = 0;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] seg_v;
    case (nib)
      4'h0:    seg_v = 7'h3F;
      4'h1:    seg_v = 7'h06;
      4'h2:    seg_v = 7'h5B;
      4'h3:    seg_v = 7'h4F;
      4'h4:    seg_v = 7'h66;
      4'h5:    seg_v = 7'h6D;
      4'h6:    seg_v = 7'h7D;
      4'h7:    seg_v = 7'h07;
      4'h8:    seg_v = 7'h7F;
      4'h9:    seg_v = 7'h6F;
      4'hA:    seg_v = 7'h77;
      4'hB:    seg_v = 7'h7C;
      4'hC:    seg_v = 7'h39;
      4'hD:    seg_v = 7'h5E;
      4'hE:    seg_v = 7'h79;
      4'hF:    seg_v = 7'h71;
      default: seg_v = 7'h00;
    endcase
    return seg_v;
  endfunction

endpackage

// File: rtl/seg_scan_mux_scan_timer.sv
// Slot timing for the display scanner: free-running slot counter, digit index
// that wraps at NUM_DIGITS-1, and a registered frame-start pulse.
module scan_timer
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIV_BITS   = DEF_DIV_BITS,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  output logic [DIV_BITS-1:0] o_cnt,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_frame_start
);

  logic [DIV_BITS-1:0] r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_frame_start;
  logic                w_wrap;
  logic                w_last_digit;

  assign w_wrap       = (r_cnt == {DIV_BITS{1'b1}});
  assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Counter, digit index and frame pulse; the index wraps explicitly so odd digit counts work.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt         <= {DIV_BITS{1'b0}};
      r_idx         <= {IDX_W{1'b0}};
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= r_cnt + DIV_BITS'(1);
      r_frame_start <= (r_cnt == {DIV_BITS{1'b0}}) && (r_idx == {IDX_W{1'b0}});
      if (w_wrap) begin
        r_idx <= w_last_digit ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_idx         = r_idx;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit LED driver: per-slot input snapshot, inter-digit
// blanking, per-digit enable, 16-level PWM brightness and registered outputs.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int SEG_W          = DEF_SEG_W,
  parameter int DIV_BITS       = DEF_DIV_BITS,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int AN_ACTIVE_LOW  = DEF_AN_ACTIVE_LOW,
  parameter int SEG_ACTIVE_LOW = DEF_SEG_ACTIVE_LOW
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [3:0]                  brightness,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [SEG_W-1:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [DIV_BITS-1:0]         w_cnt;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_frame_start;
  logic [NUM_DIGITS*SEG_W-1:0] r_snap_digits;
  logic [NUM_DIGITS-1:0]       r_snap_en;
  logic [SEG_W-1:0]            w_field [NUM_DIGITS];
  logic                        w_on;
  logic [NUM_DIGITS-1:0]       w_an_nxt;
  logic [SEG_W-1:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [SEG_W-1:0]            r_seg;

  scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIV_BITS   (DIV_BITS),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .o_cnt         (w_cnt),
    .o_idx         (w_idx),
    .o_frame_start (w_frame_start)
  );

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_field
    assign w_field[g] = r_snap_digits[g*SEG_W +: SEG_W];
  end

  // Brightness is compared live against the top four counter bits, so it acts mid-slot.
  assign w_on = (w_cnt >= DIV_BITS'(BLANK_CYCLES))
             && (w_cnt[DIV_BITS-1 -: 4] <= brightness)
             && r_snap_en[w_idx];

  // Phase decode: XOR against the idle pattern yields the active polarity for both buses.
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    if (w_on) begin
      w_an_nxt  = AN_OFF ^ (NUM_DIGITS'(1) << w_idx);
      w_seg_nxt = SEG_OFF ^ w_field[w_idx];
    end else begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_OFF;
    end
  end

  // Snapshot at each slot boundary and register the decoded drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_snap_digits <= {(NUM_DIGITS*SEG_W){1'b0}};
      r_snap_en     <= {NUM_DIGITS{1'b0}};
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
    end else begin
      if (w_cnt == {DIV_BITS{1'b0}}) begin
        r_snap_digits <= digits;
        r_snap_en     <= digit_en;
      end else begin
        r_snap_digits <= r_snap_digits;
        r_snap_en     <= r_snap_en;
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_start = w_frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a 64-clock slot and 2-clock blanking.
// Time is tracked as posedges since reset release; output at t reflects cnt (t-1)%64.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int ND  = 4;
  localparam int SW  = 7;
  localparam int DIV = 6;

  logic              clock;
  logic              reset;
  logic [ND*SW-1:0]  digits;
  logic [ND-1:0]     digit_en;
  logic [3:0]        brightness;
  logic [SW-1:0]     seg;
  logic [ND-1:0]     an;
  logic              frame_start;

  int n_checks;
  int n_errors;
  int t;

  seg_scan_mux #(
    .NUM_DIGITS     (ND),
    .SEG_W          (SW),
    .DIV_BITS       (DIV),
    .BLANK_CYCLES   (2),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .digits      (digits),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         slot;
    int         c;
    logic [3:0] en;
    logic [3:0] br;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fs;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clock);
    t = t + 1;
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, got, exp, t);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] ea, input logic [6:0] es, input logic ef);
    chk({nm, ".an"}, {28'd0, an}, {28'd0, ea});
    chk({nm, ".seg"}, {25'd0, seg}, {25'd0, es});
    chk({nm, ".fs"}, {31'd0, frame_start}, {31'd0, ef});
  endtask

  task automatic goto_pt(input int slot, input int c);
    int tgt;
    tgt = slot * 64 + c + 1;
    if (t > tgt) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL goto: t=%0d already past target %0d", t, tgt);
    end
    while (t < tgt) step();
  endtask

  function automatic vec_t mk(int s, int c, logic [3:0] en, logic [3:0] br,
                              logic [3:0] ea, logic [6:0] es, logic ef);
    vec_t v;
    v.slot = s; v.c = c; v.en = en; v.br = br;
    v.exp_an = ea; v.exp_seg = es; v.exp_fs = ef;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    t = 0;
    reset = 1'b1;
    digits = {hex_to_seg7(4'h1), hex_to_seg7(4'h2), hex_to_seg7(4'h3), hex_to_seg7(4'h4)};
    digit_en = 4'b1111;
    brightness = 4'd15;

    // digit0=66 digit1=4F digit2=5B digit3=06
    vecs.push_back(mk( 0,  0, 4'b1111, 4'd15, 4'hF, 7'h00, 1'b1));
    vecs.push_back(mk( 0,  1, 4'b1111, 4'd15, 4'hF, 7'h00, 1'b0));
    vecs.push_back(mk( 0,  2, 4'b1111, 4'd15, 4'hE, 7'h66, 1'b0));
    vecs.push_back(mk( 0, 63, 4'b1111, 4'd15, 4'hE, 7'h66, 1'b0));
    vecs.push_back(mk( 1,  2, 4'b1111, 4'd15, 4'hD, 7'h4F, 1'b0));
    vecs.push_back(mk( 2, 30, 4'b1111, 4'd15, 4'hB, 7'h5B, 1'b0));
    vecs.push_back(mk( 3, 63, 4'b1111, 4'd15, 4'h7, 7'h06, 1'b0));
    vecs.push_back(mk( 4,  0, 4'b0101, 4'd15, 4'hF, 7'h00, 1'b1));
    vecs.push_back(mk( 4, 10, 4'b0101, 4'd15, 4'hE, 7'h66, 1'b0));
    vecs.push_back(mk( 5, 10, 4'b0101, 4'd15, 4'hF, 7'h00, 1'b0));
    vecs.push_back(mk( 6, 10, 4'b0101, 4'd15, 4'hB, 7'h5B, 1'b0));
    vecs.push_back(mk( 7, 40, 4'b0101, 4'd15, 4'hF, 7'h00, 1'b0));
    vecs.push_back(mk( 8, 15, 4'b1111, 4'd3,  4'hE, 7'h66, 1'b0));
    vecs.push_back(mk( 8, 16, 4'b1111, 4'd3,  4'hF, 7'h00, 1'b0));
    vecs.push_back(mk( 9,  2, 4'b1111, 4'd3,  4'hD, 7'h4F, 1'b0));
    vecs.push_back(mk( 9, 63, 4'b1111, 4'd3,  4'hF, 7'h00, 1'b0));
    vecs.push_back(mk(10,  1, 4'b1111, 4'd0,  4'hF, 7'h00, 1'b0));
    vecs.push_back(mk(10,  3, 4'b1111, 4'd0,  4'hB, 7'h5B, 1'b0));
    vecs.push_back(mk(10,  4, 4'b1111, 4'd0,  4'hF, 7'h00, 1'b0));
    vecs.push_back(mk(11, 20, 4'b1111, 4'd0,  4'hF, 7'h00, 1'b0));
    vecs.push_back(mk(11, 21, 4'b1111, 4'd15, 4'h7, 7'h06, 1'b0));
    vecs.push_back(mk(12,  0, 4'b1111, 4'd15, 4'hF, 7'h00, 1'b1));

    // Reset held three clocks: outputs idle throughout.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("reset_hold%0d", i), 4'hF, 7'h00, 1'b0);
    end
    reset = 1'b0;
    t = 0;

    foreach (vecs[k]) begin
      digit_en   = vecs[k].en;
      brightness = vecs[k].br;
      goto_pt(vecs[k].slot, vecs[k].c);
      chk_out($sformatf("vec%0d_s%0d_c%0d", k, vecs[k].slot, vecs[k].c),
              vecs[k].exp_an, vecs[k].exp_seg, vecs[k].exp_fs);
    end

    // Mid-slot input change must not reach the outputs before the next slot-0 visit.
    goto_pt(12, 30);
    chk_out("snap_pre", 4'hE, 7'h66, 1'b0);
    digits[6:0] = 7'h7F;
    goto_pt(12, 31);
    chk_out("snap_c31", 4'hE, 7'h66, 1'b0);
    goto_pt(12, 63);
    chk_out("snap_c63", 4'hE, 7'h66, 1'b0);
    goto_pt(13, 5);
    chk_out("snap_next", 4'hD, 7'h4F, 1'b0);
    goto_pt(16, 0);
    chk_out("frame4", 4'hF, 7'h00, 1'b1);
    goto_pt(16, 5);
    chk_out("snap_new", 4'hE, 7'h7F, 1'b0);

    // One-clock reset mid-slot restarts the scan at digit 0.
    goto_pt(18, 40);
    chk_out("pre_reset", 4'hB, 7'h5B, 1'b0);
    reset = 1'b1;
    step();
    chk_out("mid_reset", 4'hF, 7'h00, 1'b0);
    reset = 1'b0;
    t = 0;
    step();
    chk_out("restart_c0", 4'hF, 7'h00, 1'b1);
    step();
    chk_out("restart_c1", 4'hF, 7'h00, 1'b0);
    step();
    chk_out("restart_c2", 4'hE, 7'h7F, 1'b0);
    goto_pt(1, 2);
    chk_out("restart_s1", 4'hD, 7'h4F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
